// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-level arbiter sharing the 10G MAC 64-bit AXI4-Stream TX port between two sources.
// Latency: 1 cycle from tvalid seen in IDLE to first output beat, then zero-latency combinational data path.
// Backpressure: m_axis_tready passes straight to the granted source; the other source, and both in IDLE/GAP, see tready=0.
//
// Ports:
//   clk156, sys_rst             : MAC core clock, asynchronous active-high reset
//   cfg_fixed_prio              : 1 = port 0 strict priority, 0 = round-robin (sampled only at arbitration)
//   s0_axis_*, s1_axis_*        : source streams (port 0 = TLP encapsulator, port 1 = test-frame generator)
//   m_axis_*                    : stream to MAC TX
//   busy                        : high while transferring a frame or holding the inter-frame gap
//   cur_sel                     : currently / most recently granted port
//   s0_frame_cnt, s1_frame_cnt  : completed frames per port, wrapping
// Optional feature: define ETH_TX_ARB_STATS_EN for live frame counters; otherwise both counters read 0.
module eth_tx_arb #(
  parameter int unsigned IFG_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  input  logic                 cfg_fixed_prio,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic [63:0]          s0_axis_tdata,
  input  logic [7:0]           s0_axis_tkeep,
  input  logic                 s0_axis_tlast,
  input  logic                 s0_axis_tuser,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic [63:0]          s1_axis_tdata,
  input  logic [7:0]           s1_axis_tkeep,
  input  logic                 s1_axis_tlast,
  input  logic                 s1_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 busy,
  output logic                 cur_sel,
  output logic [CNT_WIDTH-1:0] s0_frame_cnt,
  output logic [CNT_WIDTH-1:0] s1_frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic       HAS_GAP  = (IFG_CYCLES != 0);
  // GAP lasts IFG_CYCLES cycles: the counter starts at IFG_CYCLES-1 and leaves at 0.
  localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(IFG_CYCLES - 1) : 8'd0;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       grant;
  logic       frame_done;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    last_grant_d   = last_grant_q;
    gap_cnt_d      = gap_cnt_q;
    grant          = 1'b0;
    frame_done     = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = 64'd0;
    m_axis_tkeep   = 8'd0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a tie under round-robin consults last_grant; otherwise port 0 wins when valid.
        if (!cfg_fixed_prio && s0_axis_tvalid && s1_axis_tvalid) begin
          grant = !last_grant_q;
        end else begin
          grant = !s0_axis_tvalid;
        end
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          sel_d        = grant;
          last_grant_d = grant;
          state_d      = ST_XFER;
        end
      end

      ST_XFER: begin
        // Grant is held even if the source drops tvalid; only a tlast transfer releases it.
        if (sel_q) begin
          m_axis_tvalid  = s1_axis_tvalid;
          m_axis_tdata   = s1_axis_tdata;
          m_axis_tkeep   = s1_axis_tkeep;
          m_axis_tlast   = s1_axis_tlast;
          m_axis_tuser   = s1_axis_tuser;
          s1_axis_tready = m_axis_tready;
        end else begin
          m_axis_tvalid  = s0_axis_tvalid;
          m_axis_tdata   = s0_axis_tdata;
          m_axis_tkeep   = s0_axis_tkeep;
          m_axis_tlast   = s0_axis_tlast;
          m_axis_tuser   = s0_axis_tuser;
          s0_axis_tready = m_axis_tready;
        end
        frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        if (frame_done) begin
          if (HAS_GAP) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;  // makes port 0 the first round-robin winner
      gap_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign cur_sel = sel_q;

`ifdef ETH_TX_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] s0_cnt_q, s0_cnt_d;
  logic [CNT_WIDTH-1:0] s1_cnt_q, s1_cnt_d;

  always_comb begin
    s0_cnt_d = s0_cnt_q;
    s1_cnt_d = s1_cnt_q;
    if (frame_done && !sel_q) s0_cnt_d = s0_cnt_q + CNT_WIDTH'(1);
    if (frame_done &&  sel_q) s1_cnt_d = s1_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      s0_cnt_q <= '0;
      s1_cnt_q <= '0;
    end else begin
      s0_cnt_q <= s0_cnt_d;
      s1_cnt_q <= s1_cnt_d;
    end
  end

  assign s0_frame_cnt = s0_cnt_q;
  assign s1_frame_cnt = s1_cnt_q;
`else
  assign s0_frame_cnt = '0;
  assign s1_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed bench for eth_tx_arb (IFG_CYCLES=2 instance plus an IFG_CYCLES=0 instance).
// Sources are queue-driven; expected output beats and grant ports are listed by hand in grant order.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
module tb_eth_tx_arb;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic        sys_rst, cfg_fixed_prio, m_tready;
  logic        s0_tvalid, s0_tlast, s0_tuser, s1_tvalid, s1_tlast, s1_tuser;
  logic [63:0] s0_tdata, s1_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep;

  logic        a_s0r, a_s1r, a_mv, a_ml, a_mu, a_busy, a_sel;
  logic [63:0] a_md;
  logic [7:0]  a_mk;
  logic [31:0] a_c0, a_c1;
  logic        z_s0r, z_s1r, z_mv, z_ml, z_mu, z_busy, z_sel;
  logic [63:0] z_md;
  logic [7:0]  z_mk;
  logic [31:0] z_c0, z_c1;

  eth_tx_arb #(.IFG_CYCLES(2), .CNT_WIDTH(32)) dut (
    .clk156(clk156), .sys_rst(sys_rst), .cfg_fixed_prio(cfg_fixed_prio),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_s0r), .s0_axis_tdata(s0_tdata),
    .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_s1r), .s1_axis_tdata(s1_tdata),
    .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tvalid(a_mv), .m_axis_tready(m_tready), .m_axis_tdata(a_md),
    .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml), .m_axis_tuser(a_mu),
    .busy(a_busy), .cur_sel(a_sel), .s0_frame_cnt(a_c0), .s1_frame_cnt(a_c1)
  );

  eth_tx_arb #(.IFG_CYCLES(0), .CNT_WIDTH(32)) dut_z (
    .clk156(clk156), .sys_rst(sys_rst), .cfg_fixed_prio(cfg_fixed_prio),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(z_s0r), .s0_axis_tdata(s0_tdata),
    .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(z_s1r), .s1_axis_tdata(s1_tdata),
    .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tvalid(z_mv), .m_axis_tready(m_tready), .m_axis_tdata(z_md),
    .m_axis_tkeep(z_mk), .m_axis_tlast(z_ml), .m_axis_tuser(z_mu),
    .busy(z_busy), .cur_sel(z_sel), .s0_frame_cnt(z_c0), .s1_frame_cnt(z_c1)
  );

  // The source model and scoreboard follow whichever instance use_z selects.
  logic        use_z;
  logic        o_s0r, o_s1r, o_mv, o_ml, o_mu, o_busy;
  logic [63:0] o_md;
  logic [7:0]  o_mk;
  assign o_s0r  = use_z ? z_s0r  : a_s0r;
  assign o_s1r  = use_z ? z_s1r  : a_s1r;
  assign o_mv   = use_z ? z_mv   : a_mv;
  assign o_md   = use_z ? z_md   : a_md;
  assign o_mk   = use_z ? z_mk   : a_mk;
  assign o_ml   = use_z ? z_ml   : a_ml;
  assign o_mu   = use_z ? z_mu   : a_mu;
  assign o_busy = use_z ? z_busy : a_busy;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  beat_t       q0[$], q1[$], expq[$];
  logic        expp[$];
  bit          holes, stalls, saw_r1;
  logic [7:0]  rdy_pat  = 8'b1011_0110;
  logic [7:0]  hole_pat = 8'b0010_0100;
  logic        log_mv[0:1023];
  logic        log_busy[0:1023];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef ETH_TX_ARB_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // Beat b of an n-beat frame f from port p; data carries port/frame/beat so misrouting is visible.
  function automatic beat_t mk(input int p, input int f, input int b, input int n, input bit u);
    beat_t r;
    r.d = {8'(p), 8'(f), 32'h5A5A_0000 ^ 32'(f * 1234), 16'(b)};
    r.l = (b == n - 1);
    r.k = r.l ? 8'h0F : 8'hFF;
    r.u = u && r.l;
    return r;
  endfunction

  task automatic add_src(input int p, input int f, input int n, input bit u);
    for (int b = 0; b < n; b++) begin
      if (p == 0) q0.push_back(mk(p, f, b, n, u));
      else        q1.push_back(mk(p, f, b, n, u));
    end
  endtask

  task automatic add_exp(input int p, input int f, input int n, input bit u);
    for (int b = 0; b < n; b++) begin
      expq.push_back(mk(p, f, b, n, u));
      expp.push_back(p[0]);
    end
  endtask

  function automatic logic [31:0] pack_log(input bit use_busy, input int c0, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = use_busy ? log_busy[c0 + i] : log_mv[c0 + i];
    return r;
  endfunction

  // One clock cycle: drive sources at the falling edge, sample/score, advance to next falling edge.
  task automatic step();
    beat_t b0, b1;
    beat_t eb;
    b0 = (q0.size() > 0) ? q0[0] : '0;
    b1 = (q1.size() > 0) ? q1[0] : '0;
    // Holes only fall on non-first beats, so arbitration outcomes stay hand-predictable.
    s0_tvalid = (q0.size() > 0) && !(holes && (b0.d[15:0] != 16'd0) && hole_pat[cyc % 8]);
    s1_tvalid = (q1.size() > 0) && !(holes && (b1.d[15:0] != 16'd0) && hole_pat[(cyc + 3) % 8]);
    {s0_tdata, s0_tkeep, s0_tlast, s0_tuser} = b0;
    {s1_tdata, s1_tkeep, s1_tlast, s1_tuser} = b1;
    m_tready = stalls ? rdy_pat[cyc % 8] : 1'b1;
    #1;
    if (cyc < 1024) begin
      log_mv[cyc]   = o_mv;
      log_busy[cyc] = o_busy;
    end
    if (o_s1r) saw_r1 = 1'b1;
    if (o_s0r || o_s1r) chk("one_tready", 96'(o_s0r & o_s1r), 96'd0);
    if (o_mv && m_tready) begin
      chk("beat_expected", 96'(expq.size() > 0), 96'd1);
      if (expq.size() > 0) begin
        eb = expq.pop_front();
        chk("beat_data", 96'({o_md, o_mk, o_ml, o_mu}), 96'(eb));
        chk("beat_port", 96'(o_s1r), 96'(expp.pop_front()));
        chk("beat_src_rdy", 96'(o_s0r | o_s1r), 96'd1);
      end
    end
    if (s0_tvalid && o_s0r) void'(q0.pop_front());
    if (s1_tvalid && o_s1r) void'(q1.pop_front());
    @(posedge clk156);
    @(negedge clk156);
    cyc++;
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int k;
    k = 0;
    while (expq.size() > 0 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_drained"}, 96'(expq.size()), 96'd0);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    expq.delete();
    expp.delete();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  int c0;
  int k;

  initial begin
    use_z = 1'b0; holes = 1'b0; stalls = 1'b0; saw_r1 = 1'b0;
    cfg_fixed_prio = 1'b0; m_tready = 1'b1; sys_rst = 1'b1;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0; s0_tuser = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tuser = 1'b0;
    #1;
    chk("rst_m_tvalid", 96'(a_mv), 96'd0);
    chk("rst_s0_tready", 96'(a_s0r), 96'd0);
    chk("rst_s1_tready", 96'(a_s1r), 96'd0);
    chk("rst_busy", 96'(a_busy), 96'd0);
    chk("rst_cur_sel", 96'(a_sel), 96'd0);
    chk("rst_m_tdata", 96'(a_md), 96'd0);
    chk("rst_cnt0", 96'(a_c0), 96'd0);
    chk("rst_cnt1", 96'(a_c1), 96'd0);
    @(negedge clk156);
    sys_rst = 1'b0;

    // Two back-to-back 4-beat frames on port 0: 1-cycle grant, 4 beats, 3 dead cycles.
    add_src(0, 1, 4, 0); add_src(0, 2, 4, 0);
    add_exp(0, 1, 4, 0); add_exp(0, 2, 4, 0);
    c0 = cyc;
    repeat (6) step();
    chk("t1_cnt0_one_frame", 96'(a_c0), 96'(exp_cnt(1)));
    repeat (9) step();
    chk("t1_tvalid_timeline", 96'(pack_log(1'b0, c0, 15)), 96'h0F1E);
    chk("t1_busy_timeline", 96'(pack_log(1'b1, c0, 15)), 96'h3F7E);
    chk("t1_all_beats", 96'(expq.size()), 96'd0);
    chk("t1_cnt0", 96'(a_c0), 96'(exp_cnt(2)));
    chk("t1_cnt1", 96'(a_c1), 96'd0);

    // Round-robin, both ports continuously valid with 3-beat frames: grants alternate 0,1,0,1,0,1.
    do_reset();
    cfg_fixed_prio = 1'b0;
    for (int f = 0; f < 3; f++) begin
      add_src(0, 16 + f, 3, 0); add_src(1, 32 + f, 3, 0);
      add_exp(0, 16 + f, 3, 0); add_exp(1, 32 + f, 3, 0);
    end
    run_until_empty(200, "t2");
    chk("t2_cnt0", 96'(a_c0), 96'(exp_cnt(3)));
    chk("t2_cnt1", 96'(a_c1), 96'(exp_cnt(3)));

    // Fixed priority with the same stimulus: port 0 keeps winning, port 1 never sees tready.
    do_reset();
    cfg_fixed_prio = 1'b1;
    saw_r1 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      add_src(0, 16 + f, 3, 0); add_src(1, 32 + f, 3, 0);
      add_exp(0, 16 + f, 3, 0);
    end
    run_until_empty(200, "t3");
    chk("t3_s1_tready_seen", 96'(saw_r1), 96'd0);
    chk("t3_cnt0", 96'(a_c0), 96'(exp_cnt(3)));
    chk("t3_cnt1", 96'(a_c1), 96'd0);

    // Output stalls and mid-frame source holes; tuser passes through on port 0's last beat.
    do_reset();
    cfg_fixed_prio = 1'b0;
    holes = 1'b1; stalls = 1'b1;
    add_src(0, 4, 4, 1); add_src(1, 5, 5, 0);
    add_exp(0, 4, 4, 1); add_exp(1, 5, 5, 0);
    run_until_empty(300, "t4");
    holes = 1'b0; stalls = 1'b0;
    chk("t4_cnt0", 96'(a_c0), 96'(exp_cnt(1)));
    chk("t4_cnt1", 96'(a_c1), 96'(exp_cnt(1)));

    // Reset on beat 2 of a 5-beat port-0 frame, then check port 0 wins the next tie.
    add_src(0, 6, 5, 0);
    for (int b = 0; b < 2; b++) begin
      expq.push_back(mk(0, 6, b, 5, 0));
      expp.push_back(1'b0);
    end
    k = 0;
    while (q0.size() > 3 && k < 50) begin
      step();
      k++;
    end
    chk("t5_reached_beat2", 96'(q0.size()), 96'd3);
    sys_rst = 1'b1;
    #1;
    chk("t5_rst_m_tvalid", 96'(a_mv), 96'd0);
    chk("t5_rst_s0_tready", 96'(a_s0r), 96'd0);
    chk("t5_rst_busy", 96'(a_busy), 96'd0);
    chk("t5_rst_cur_sel", 96'(a_sel), 96'd0);
    chk("t5_rst_cnt0", 96'(a_c0), 96'd0);
    chk("t5_rst_cnt1", 96'(a_c1), 96'd0);
    q0.delete();
    step();
    sys_rst = 1'b0;
    chk("t5_partial_beats", 96'(expq.size()), 96'd0);
    add_src(0, 7, 2, 0); add_src(1, 7, 2, 0);
    add_exp(0, 7, 2, 0); add_exp(1, 7, 2, 0);
    run_until_empty(100, "t5");

    // IFG_CYCLES = 0 instance: single-beat frames from both ports, one beat every 2 cycles.
    do_reset();
    use_z = 1'b1;
    add_src(0, 8, 1, 0); add_src(0, 9, 1, 0); add_src(1, 8, 1, 0); add_src(1, 9, 1, 0);
    add_exp(0, 8, 1, 0); add_exp(1, 8, 1, 0); add_exp(0, 9, 1, 0); add_exp(1, 9, 1, 0);
    c0 = cyc;
    repeat (8) step();
    chk("t6_tvalid_timeline", 96'(pack_log(1'b0, c0, 8)), 96'h00AA);
    chk("t6_all_beats", 96'(expq.size()), 96'd0);
    chk("t6_cnt0", 96'(z_c0), 96'(exp_cnt(2)));
    chk("t6_cnt1", 96'(z_c1), 96'(exp_cnt(2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
